fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Parametrised operand-forwarding and load-use hazard unit for the 5-stage rv32i pipeline, sitting between the ID/EX register and the EX-stage ALU/branch inputs. It forwards results from MEM and WB to `NUM_SRC` EX source operands. A bubble FSM enforces a configurable load-use stall. Per-source hold registers capture WB results that retire while EX is held, so operands latched in ID/EX cannot go stale.

## Interface
- `NUM_SRC`, 2: number of EX source operands (1..4).
- `XLEN`, 32: datapath width.
- `LOAD_USE_BUBBLES`, 1: bubbles per load-use hazard (1..3).

- `clk` in 1: clock.
- `rst_n` in 1: synchronous, active-low reset.
- `ex_valid` in 1: EX holds a live instruction.
- `ex_flush` in 1: EX instruction killed this cycle.
- `ex_rs_used` in NUM_SRC: source i is read.
- `ex_rs` in NUM_SRC×5: source register addresses.
- `ex_rs_data` in NUM_SRC×XLEN: values latched in ID/EX.
- `mem_valid`, `mem_wr_en` in 1 each: MEM live / writes rd.
- `mem_rd` in 5: MEM destination register.
- `mem_sel` in regfilemux_sel_t: MEM writeback select.
- `mem_alu_out`, `mem_u_imm`, `mem_pc` in XLEN each: MEM-stage values.
- `wb_valid`, `wb_wr_en` in 1 each: WB live / writes rd.
- `wb_rd` in 5: WB destination register.
- `wb_data` in XLEN: final regfile write value, already load-extracted.
- `pipe_stall_in` in 1: global freeze (cache miss).
- `fwd_data` out NUM_SRC×XLEN: forwarded operands.
- `fwd_src` out NUM_SRC×fwd_src_t: chosen source, for debug and coverage.
- `bubble` out 1: hold IF/ID/EX and inject a nop into EX/MEM.

## Operation
- Per-source match conditions:
  - `mem_hit[i]`: `mem_valid & mem_wr_en & mem_rd==ex_rs[i] & ex_rs[i]!=0`.
  - `wb_hit[i]`: the same test using the WB fields.
- Operand priority for source i:
  - `ex_rs[i]==0`: output 0 (FWD_RF).
  - `mem_hit` with `mem_sel` = alu_out / pc_plus4 / u_imm: output `mem_alu_out` / `mem_pc+4` / `mem_u_imm` (FWD_MEM).
  - `wb_hit`: output `wb_data` (FWD_WB).
  - `hold_v[i]`: output `hold_q[i]` (FWD_HOLD).
  - Otherwise: output `ex_rs_data[i]` (FWD_RF).
- Load-use hazard:
  - Condition: `ex_valid & ex_rs_used[i] & mem_hit[i]` for any i, with `mem_sel` a load or any select other than alu_out/pc_plus4/u_imm.
  - While a hazard is present, `fwd_data[i]` is don't-care.
- FSM states: RUN, LU_STALL, plus a 2-bit counter `cnt`.
  - RUN: `bubble` = hazard. On an edge with bubble and `!pipe_stall_in`: if `LOAD_USE_BUBBLES>1`, go to LU_STALL with `cnt=LOAD_USE_BUBBLES-1`.
  - LU_STALL: `bubble`=1. On an edge with `!pipe_stall_in`: if `cnt==1`, go to RUN; else `cnt--`.
  - `pipe_stall_in`=1 freezes the FSM, counter and hold registers.
- Hold capture per source, on an edge where all of these hold: EX held (`bubble & !pipe_stall_in`), `ex_valid`, `wb_hit[i]`.
  - Effect: `hold_q[i]<=wb_data`, `hold_v[i]<=1`. A newer WB hit overwrites.
- Hold clear: all `hold_v` cleared on an edge where EX advances (`!bubble & !pipe_stall_in`) or `ex_flush`.
- `ex_flush`: forces `bubble`=0 that cycle. Next state is RUN with `cnt`=0.

## Timing
- Forward mux and `bubble` are combinational from inputs and state; zero latency.
- Hold registers and FSM update on `clk` rising edge only.
- Reset (`rst_n`=0 at edge):
  - State: RUN, `cnt`=0, `hold_v`=0, `hold_q`=0.
  - Outputs while `rst_n`=0: `bubble`=0, `fwd_src`=FWD_RF, `fwd_data`=`ex_rs_data` (0 for x0).
- Reset mid-stall abandons the stall immediately.
- Simultaneous cases:
  - MEM and WB match the same rs: MEM wins.
  - WB hit and `hold_v`: WB wins and is captured.
  - `ex_flush` with hazard: flush wins.
  - Hazard on both sources: a single bubble sequence.

## Structure
- Add to `rv32i_types`:
  - `typedef enum logic[1:0] fwd_src_t {FWD_RF, FWD_MEM, FWD_WB, FWD_HOLD}`.
  - Function `is_fwdable(regfilemux_sel_t)` returning 1 for alu_out, pc_plus4, u_imm.
- Sub-module `fwd_operand_sel`: one source's match logic, priority mux and hold register. Instantiated `NUM_SRC` times via generate.
- Top level: FSM and hazard OR-reduction.

## Test plan
- ALU→ALU: MEM `add x5` (alu_out=0x10), EX `rs1=x5` → `fwd_data[0]`=0x10, FWD_MEM, `bubble`=0.
- Load-use, `LOAD_USE_BUBBLES`=1:
  - MEM `lw x6`, EX `rs2=x6` → `bubble`=1 for exactly 1 cycle.
  - Next cycle WB `wb_data`=0xDEADBEEF → `fwd_data[1]`=0xDEADBEEF, FWD_WB.
- `LOAD_USE_BUBBLES`=3: same stimulus → `bubble` high 3 cycles. Cycles 3–4 show FWD_HOLD=0xDEADBEEF, and `hold_v` clears when EX advances.
- `pipe_stall_in` raised in LU_STALL for 4 cycles → `cnt` frozen; the total count of non-stalled bubble cycles stays at `LOAD_USE_BUBBLES`.
- Priority: MEM rd=x7 (0x1) and WB rd=x7 (0x2) → 0x1. `rs1=x0` while WB writes x0 → 0.
- Boundary events:
  - `ex_flush` in LU_STALL → `bubble`=0 that cycle, RUN next cycle.
  - `rst_n`=0 mid-stall → RUN, `hold_v`=0 after the edge.

Source files
------------

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared rv32i pipeline types used by the forwarding/hazard unit.
package rv32i_types;

    localparam int unsigned REG_AW = 5;

    typedef enum logic [3:0] {
        alu_out  = 4'd0,
        br_en    = 4'd1,
        u_imm    = 4'd2,
        lw       = 4'd3,
        pc_plus4 = 4'd4,
        lb       = 4'd5,
        lbu      = 4'd6,
        lh       = 4'd7,
        lhu      = 4'd8
    } regfilemux_sel_t;

    typedef enum logic [1:0] {FWD_RF, FWD_MEM, FWD_WB, FWD_HOLD} fwd_src_t;

    typedef enum logic {RUN, LU_STALL} lu_state_t;

    // MEM-stage selects whose final value already exists in MEM.
    function automatic logic is_fwdable(regfilemux_sel_t sel);
        return (sel == alu_out) || (sel == pc_plus4) || (sel == u_imm);
    endfunction

endpackage

// File: rtl/fwd_operand_sel.sv
// One EX source operand: MEM/WB match, forwarding priority mux and the
// hold register that keeps a WB result alive while EX is held.
module fwd_operand_sel
    import rv32i_types::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [REG_AW-1:0]   rs,
    input  logic [XLEN-1:0]     rs_data,
    input  logic                mem_valid,
    input  logic                mem_wr_en,
    input  logic [REG_AW-1:0]   mem_rd,
    input  regfilemux_sel_t     mem_sel,
    input  logic [XLEN-1:0]     mem_alu_out,
    input  logic [XLEN-1:0]     mem_u_imm,
    input  logic [XLEN-1:0]     mem_pc,
    input  logic                wb_valid,
    input  logic                wb_wr_en,
    input  logic [REG_AW-1:0]   wb_rd,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                hold_cap,
    input  logic                hold_clr,
    output logic [XLEN-1:0]     fwd_data,
    output logic [1:0]          fwd_src,
    output logic                mem_hit
);

    logic            rs_nz;
    logic            wb_hit;
    logic            hold_v;
    logic [XLEN-1:0] hold_q;
    fwd_src_t        sel_src;

    assign rs_nz   = (rs != '0);
    assign mem_hit = mem_valid & mem_wr_en & (mem_rd == rs) & rs_nz;
    assign wb_hit  = wb_valid & wb_wr_en & (wb_rd == rs) & rs_nz;

    // Hold register: capture WB results retiring while EX is frozen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_v <= 1'b0;
            hold_q <= '0;
        end else if (hold_clr) begin
            hold_v <= 1'b0;
        end else if (hold_cap && wb_hit) begin
            hold_v <= 1'b1;
            hold_q <= wb_data;
        end
    end

    always_comb begin
        sel_src  = FWD_RF;
        fwd_data = rs_data;
        if (!rs_nz) begin
            fwd_data = '0;
        end else if (!rst_n) begin
            fwd_data = rs_data;
        end else if (mem_hit && is_fwdable(mem_sel)) begin
            sel_src = FWD_MEM;
            case (mem_sel)
                pc_plus4: fwd_data = mem_pc + XLEN'(4);
                u_imm:    fwd_data = mem_u_imm;
                default:  fwd_data = mem_alu_out;
            endcase
        end else if (wb_hit) begin
            sel_src  = FWD_WB;
            fwd_data = wb_data;
        end else if (hold_v) begin
            sel_src  = FWD_HOLD;
            fwd_data = hold_q;
        end
    end

    assign fwd_src = sel_src;

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding plus load-use bubble sequencer for rv32i.
module fwd_hazard_unit
    import rv32i_types::*;
#(
    parameter int unsigned NUM_SRC          = 2,
    parameter int unsigned XLEN             = 32,
    parameter int unsigned LOAD_USE_BUBBLES = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ex_valid,
    input  logic                        ex_flush,
    input  logic [NUM_SRC-1:0]          ex_rs_used,
    input  logic [NUM_SRC*REG_AW-1:0]   ex_rs,
    input  logic [NUM_SRC*XLEN-1:0]     ex_rs_data,
    input  logic                        mem_valid,
    input  logic                        mem_wr_en,
    input  logic [REG_AW-1:0]           mem_rd,
    input  regfilemux_sel_t             mem_sel,
    input  logic [XLEN-1:0]             mem_alu_out,
    input  logic [XLEN-1:0]             mem_u_imm,
    input  logic [XLEN-1:0]             mem_pc,
    input  logic                        wb_valid,
    input  logic                        wb_wr_en,
    input  logic [REG_AW-1:0]           wb_rd,
    input  logic [XLEN-1:0]             wb_data,
    input  logic                        pipe_stall_in,
    output logic [NUM_SRC*XLEN-1:0]     fwd_data,
    output logic [NUM_SRC*2-1:0]        fwd_src,
    output logic                        bubble
);

    lu_state_t          state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [NUM_SRC-1:0] mem_hit;
    logic               hazard;
    logic               hold_cap;
    logic               hold_clr;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_operand_sel #(.XLEN(XLEN)) u_sel (
            .clk         (clk),
            .rst_n       (rst_n),
            .rs          (ex_rs[i*REG_AW +: REG_AW]),
            .rs_data     (ex_rs_data[i*XLEN +: XLEN]),
            .mem_valid   (mem_valid),
            .mem_wr_en   (mem_wr_en),
            .mem_rd      (mem_rd),
            .mem_sel     (mem_sel),
            .mem_alu_out (mem_alu_out),
            .mem_u_imm   (mem_u_imm),
            .mem_pc      (mem_pc),
            .wb_valid    (wb_valid),
            .wb_wr_en    (wb_wr_en),
            .wb_rd       (wb_rd),
            .wb_data     (wb_data),
            .hold_cap    (hold_cap),
            .hold_clr    (hold_clr),
            .fwd_data    (fwd_data[i*XLEN +: XLEN]),
            .fwd_src     (fwd_src[i*2 +: 2]),
            .mem_hit     (mem_hit[i])
        );
    end

    // Any used source waiting on a MEM value not yet available.
    assign hazard = ex_valid & (|(ex_rs_used & mem_hit)) & ~is_fwdable(mem_sel);

    assign hold_cap = bubble & ~pipe_stall_in & ex_valid;
    assign hold_clr = (~bubble & ~pipe_stall_in) | ex_flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bubble  = 1'b0;
        case (state_q)
            RUN:      bubble = hazard;
            LU_STALL: bubble = 1'b1;
            default:  bubble = 1'b0;
        endcase
        if (ex_flush || !rst_n) begin
            bubble = 1'b0;
        end
        // Flush abandons any bubble sequence; a global freeze holds it.
        if (ex_flush) begin
            state_d = RUN;
            cnt_d   = 2'd0;
        end else if (!pipe_stall_in) begin
            case (state_q)
                RUN: begin
                    if (bubble && (LOAD_USE_BUBBLES > 1)) begin
                        state_d = LU_STALL;
                        cnt_d   = 2'(LOAD_USE_BUBBLES - 1);
                    end
                end
                LU_STALL: begin
                    if (cnt_q <= 2'd1) begin
                        state_d = RUN;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench: two units (1 and 3 load-use bubbles) share one stimulus.
module tb_fwd_hazard_unit;
    import rv32i_types::*;

    logic                  clk;
    logic                  rst_n;
    logic                  ex_valid;
    logic                  ex_flush;
    logic [1:0]            ex_rs_used;
    logic [9:0]            ex_rs;
    logic [63:0]           ex_rs_data;
    logic                  mem_valid;
    logic                  mem_wr_en;
    logic [4:0]            mem_rd;
    regfilemux_sel_t       mem_sel;
    logic [31:0]           mem_alu_out;
    logic [31:0]           mem_u_imm;
    logic [31:0]           mem_pc;
    logic                  wb_valid;
    logic                  wb_wr_en;
    logic [4:0]            wb_rd;
    logic [31:0]           wb_data;
    logic                  pipe_stall_in;
    logic [63:0]           fwd_data1, fwd_data3;
    logic [3:0]            fwd_src1, fwd_src3;
    logic                  bubble1, bubble3;

    typedef struct {
        logic [63:0] name;
        logic        b1;
        logic        b3;
        logic        cd0;
        logic        cd1;
        logic        cu;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  s0;
        logic [1:0]  s1;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp;
    int   n_bad;

    fwd_hazard_unit #(.NUM_SRC(2), .XLEN(32), .LOAD_USE_BUBBLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_flush(ex_flush),
        .ex_rs_used(ex_rs_used), .ex_rs(ex_rs), .ex_rs_data(ex_rs_data),
        .mem_valid(mem_valid), .mem_wr_en(mem_wr_en), .mem_rd(mem_rd),
        .mem_sel(mem_sel), .mem_alu_out(mem_alu_out), .mem_u_imm(mem_u_imm),
        .mem_pc(mem_pc), .wb_valid(wb_valid), .wb_wr_en(wb_wr_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .pipe_stall_in(pipe_stall_in),
        .fwd_data(fwd_data1), .fwd_src(fwd_src1), .bubble(bubble1)
    );

    fwd_hazard_unit #(.NUM_SRC(2), .XLEN(32), .LOAD_USE_BUBBLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_flush(ex_flush),
        .ex_rs_used(ex_rs_used), .ex_rs(ex_rs), .ex_rs_data(ex_rs_data),
        .mem_valid(mem_valid), .mem_wr_en(mem_wr_en), .mem_rd(mem_rd),
        .mem_sel(mem_sel), .mem_alu_out(mem_alu_out), .mem_u_imm(mem_u_imm),
        .mem_pc(mem_pc), .wb_valid(wb_valid), .wb_wr_en(wb_wr_en), .wb_rd(wb_rd),
        .wb_data(wb_data), .pipe_stall_in(pipe_stall_in),
        .fwd_data(fwd_data3), .fwd_src(fwd_src3), .bubble(bubble3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input logic [63:0] nm, input string fld,
                         input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s %s: got 0x%0h want 0x%0h", nm, fld, act, exp_v);
        end
    endtask

    // Monitor: one expected entry per cycle, sampled on the falling edge.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check(e.name, "bubble1", 32'(bubble1), 32'(e.b1));
            check(e.name, "bubble3", 32'(bubble3), 32'(e.b3));
            if (e.cd0) begin
                check(e.name, "data0_u3", fwd_data3[31:0], e.d0);
                check(e.name, "src0_u3", 32'(fwd_src3[1:0]), 32'(e.s0));
                if (e.cu) begin
                    check(e.name, "data0_u1", fwd_data1[31:0], e.d0);
                    check(e.name, "src0_u1", 32'(fwd_src1[1:0]), 32'(e.s0));
                end
            end
            if (e.cd1) begin
                check(e.name, "data1_u3", fwd_data3[63:32], e.d1);
                check(e.name, "src1_u3", 32'(fwd_src3[3:2]), 32'(e.s1));
                if (e.cu) begin
                    check(e.name, "data1_u1", fwd_data1[63:32], e.d1);
                    check(e.name, "src1_u1", 32'(fwd_src1[3:2]), 32'(e.s1));
                end
            end
        end
    end

    task automatic idle();
        rst_n = 1'b1; ex_valid = 1'b0; ex_flush = 1'b0; ex_rs_used = 2'b00;
        ex_rs = '0; ex_rs_data = '0;
        mem_valid = 1'b0; mem_wr_en = 1'b0; mem_rd = '0; mem_sel = alu_out;
        mem_alu_out = '0; mem_u_imm = '0; mem_pc = '0;
        wb_valid = 1'b0; wb_wr_en = 1'b0; wb_rd = '0; wb_data = '0;
        pipe_stall_in = 1'b0;
    endtask

    task automatic setsrc(input logic [4:0] r0, input logic [31:0] v0,
                          input logic [4:0] r1, input logic [31:0] v1);
        ex_rs      = {r1, r0};
        ex_rs_data = {v1, v0};
    endtask

    task automatic mem_set(input logic [4:0] rd, input regfilemux_sel_t sel,
                           input logic [31:0] val);
        mem_valid = 1'b1; mem_wr_en = 1'b1; mem_rd = rd;
        mem_sel = sel; mem_alu_out = val;
    endtask

    task automatic mem_off();
        mem_valid = 1'b0; mem_wr_en = 1'b0;
    endtask

    task automatic wb_set(input logic [4:0] rd, input logic [31:0] val);
        wb_valid = 1'b1; wb_wr_en = 1'b1; wb_rd = rd; wb_data = val;
    endtask

    task automatic wb_off();
        wb_valid = 1'b0; wb_wr_en = 1'b0;
    endtask

    // Queue the expectation for the inputs just driven, then advance a cycle.
    task automatic step(input logic [63:0] nm, input logic b1, input logic b3,
                        input logic cd0, input logic [31:0] d0, input fwd_src_t s0,
                        input logic cd1, input logic [31:0] d1, input fwd_src_t s1,
                        input logic cu);
        exp_t x;
        x.name = nm; x.b1 = b1; x.b3 = b3; x.cd0 = cd0; x.cd1 = cd1; x.cu = cu;
        x.d0 = d0; x.d1 = d1; x.s0 = s0; x.s1 = s1;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        idle();
        rst_n = 1'b0; ex_valid = 1'b1; ex_rs_used = 2'b11;
        setsrc(5'd5, 32'h55, 5'd0, 32'h77);
        mem_set(5'd5, lw, 32'h10);
        @(posedge clk);
        #1;
        step("rst", 0, 0, 1, 32'h55, FWD_RF, 1, 32'h0, FWD_RF, 1);

        // MEM forwarding for each forwardable select
        idle(); ex_valid = 1'b1; ex_rs_used = 2'b01;
        setsrc(5'd5, 32'hAAAA, 5'd6, 32'h66);
        mem_set(5'd5, alu_out, 32'h10);
        step("alu", 0, 0, 1, 32'h10, FWD_MEM, 1, 32'h66, FWD_RF, 1);
        mem_sel = pc_plus4; mem_pc = 32'h100;
        step("pc4", 0, 0, 1, 32'h104, FWD_MEM, 1, 32'h66, FWD_RF, 1);
        mem_sel = u_imm; mem_u_imm = 32'h1234_5000;
        step("uimm", 0, 0, 1, 32'h1234_5000, FWD_MEM, 1, 32'h66, FWD_RF, 1);

        // Priority and x0
        idle(); ex_valid = 1'b1; ex_rs_used = 2'b11;
        setsrc(5'd7, 32'h99, 5'd0, 32'h33);
        mem_set(5'd7, alu_out, 32'h1);
        wb_set(5'd7, 32'h2);
        step("prio", 0, 0, 1, 32'h1, FWD_MEM, 1, 32'h0, FWD_RF, 1);
        mem_off();
        step("wbhit", 0, 0, 1, 32'h2, FWD_WB, 1, 32'h0, FWD_RF, 1);
        setsrc(5'd0, 32'h88, 5'd0, 32'h33);
        wb_set(5'd0, 32'h2);
        step("x0", 0, 0, 1, 32'h0, FWD_RF, 1, 32'h0, FWD_RF, 1);

        // Load in MEM but no live consumer: no bubble
        idle(); ex_valid = 1'b1; ex_rs_used = 2'b00;
        setsrc(5'd6, 32'h1111, 5'd6, 32'h2222);
        mem_set(5'd6, lw, 32'h0);
        step("nouse", 0, 0, 1, 32'h1111, FWD_RF, 1, 32'h2222, FWD_RF, 1);
        ex_valid = 1'b0; ex_rs_used = 2'b11;
        step("novld", 0, 0, 1, 32'h1111, FWD_RF, 1, 32'h2222, FWD_RF, 1);

        // Load-use on source 1, then WB forward and hold
        idle(); ex_valid = 1'b1; ex_rs_used = 2'b10;
        setsrc(5'd3, 32'h3, 5'd6, 32'h1111);
        mem_set(5'd6, lw, 32'h0);
        step("lu_a", 1, 1, 1, 32'h3, FWD_RF, 0, 32'h0, FWD_RF, 1);
        mem_off(); wb_set(5'd6, 32'hDEAD_BEEF);
        step("lu_b", 0, 1, 1, 32'h3, FWD_RF, 1, 32'hDEAD_BEEF, FWD_WB, 1);
        wb_off();
        step("lu_c", 0, 1, 1, 32'h3, FWD_RF, 1, 32'hDEAD_BEEF, FWD_HOLD, 0);
        step("lu_d", 0, 0, 1, 32'h3, FWD_RF, 1, 32'hDEAD_BEEF, FWD_HOLD, 0);
        step("lu_e", 0, 0, 1, 32'h3, FWD_RF, 1, 32'h1111, FWD_RF, 1);

        // Non-forwardable select hazard, then a 4-cycle freeze in LU_STALL
        mem_set(5'd6, br_en, 32'h0);
        step("bre_f", 1, 1, 1, 32'h3, FWD_RF, 0, 32'h0, FWD_RF, 1);
        mem_off(); pipe_stall_in = 1'b1; wb_set(5'd6, 32'hCAFE_0001);
        step("stl_g", 0, 1, 1, 32'h3, FWD_RF, 1, 32'hCAFE_0001, FWD_WB, 1);
        wb_off();
        for (int k = 0; k < 3; k++) begin
            step("stl_h", 0, 1, 1, 32'h3, FWD_RF, 1, 32'h1111, FWD_RF, 1);
        end
        pipe_stall_in = 1'b0;
        step("stl_k", 0, 1, 1, 32'h3, FWD_RF, 1, 32'h1111, FWD_RF, 1);
        step("stl_l", 0, 1, 1, 32'h3, FWD_RF, 1, 32'h1111, FWD_RF, 1);
        step("stl_m", 0, 0, 1, 32'h3, FWD_RF, 1, 32'h1111, FWD_RF, 1);

        // Flush in LU_STALL, then flush against a fresh hazard
        mem_set(5'd6, lw, 32'h0);
        step("fl_n", 1, 1, 1, 32'h3, FWD_RF, 0, 32'h0, FWD_RF, 1);
        mem_off(); wb_set(5'd6, 32'hBEEF_0002);
        step("fl_o", 0, 1, 1, 32'h3, FWD_RF, 1, 32'hBEEF_0002, FWD_WB, 1);
        wb_off(); ex_flush = 1'b1;
        step("fl_p", 0, 0, 1, 32'h3, FWD_RF, 1, 32'hBEEF_0002, FWD_HOLD, 0);
        ex_flush = 1'b0;
        step("fl_q", 0, 0, 1, 32'h3, FWD_RF, 1, 32'h1111, FWD_RF, 1);
        mem_set(5'd6, lw, 32'h0); ex_flush = 1'b1;
        step("fl_r", 0, 0, 1, 32'h3, FWD_RF, 0, 32'h0, FWD_RF, 1);
        mem_off(); ex_flush = 1'b0;
        step("fl_s", 0, 0, 1, 32'h3, FWD_RF, 1, 32'h1111, FWD_RF, 1);

        // Reset while stalled with a captured hold value
        mem_set(5'd6, lw, 32'h0);
        step("rs_t", 1, 1, 1, 32'h3, FWD_RF, 0, 32'h0, FWD_RF, 1);
        mem_off(); wb_set(5'd6, 32'h1234_0003);
        step("rs_u", 0, 1, 1, 32'h3, FWD_RF, 1, 32'h1234_0003, FWD_WB, 1);
        wb_off(); rst_n = 1'b0;
        step("rs_v", 0, 0, 1, 32'h3, FWD_RF, 1, 32'h1111, FWD_RF, 1);
        rst_n = 1'b1;
        step("rs_w", 0, 0, 1, 32'h3, FWD_RF, 1, 32'h1111, FWD_RF, 1);

        idle();
        repeat (4) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
